// File: rtl/reg_file_bypass.sv
// ----------------------------------------------------------------------------
// reg_file_bypass
//   Two-read / one-write register file that sits between decode (read
//   addresses) and writeback (write port).
//
//   After every reset a clear sequencer writes zero into each entry, one per
//   clock, and raises Busy. While Busy is high, writes are dropped and both
//   read ports return zero.
//
//   Once the sequencer finishes (RUN), the reads are combinational:
//     - With BYPASS set, a write to the address being read in the same cycle
//       is forwarded to that read port.
//     - With ZERO_REG set, entry 0 always reads zero and ignores writes.
//
// Parameters
//   WIDTH     data bits per register
//   ADDR_W    address bits; DEPTH = 2**ADDR_W entries
//   ZERO_REG  1: entry 0 hardwired to zero; 0: entry 0 is ordinary
//   BYPASS    1: same-cycle write data forwarded to matching read ports
//
// Ports
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset (restarts the clear sequence)
//   Read1      read port 1 address
//   Read2      read port 2 address
//   WriteReg   write address
//   RegWrite   write enable, sampled at posedge clk
//   WriteData  write data
//   Data1      read port 1 data (combinational)
//   Data2      read port 2 data (combinational)
//   Busy       high while the clear sequence runs
// ----------------------------------------------------------------------------
module reg_file_bypass #(
   parameter int unsigned WIDTH    = 32,
   parameter int unsigned ADDR_W   = 5,
   parameter bit          ZERO_REG = 1'b1,
   parameter bit          BYPASS   = 1'b1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [ADDR_W-1:0] Read1,
   input  logic [ADDR_W-1:0] Read2,
   input  logic [ADDR_W-1:0] WriteReg,
   input  logic              RegWrite,
   input  logic [WIDTH-1:0]  WriteData,
   output logic [WIDTH-1:0]  Data1,
   output logic [WIDTH-1:0]  Data2,
   output logic              Busy
);

   localparam int unsigned       DEPTH     = 1 << ADDR_W;
   localparam logic [ADDR_W-1:0] LAST_ADDR = '1;   // DEPTH-1

   typedef enum logic {
      CLEAR,
      RUN
   } state_t;

   state_t            state;
   state_t            next_state;
   logic [ADDR_W-1:0] clr_ptr;
   logic [ADDR_W-1:0] next_ptr;
   logic              clr_we;
   logic              wr_drop;
   logic              wr_ok;

   logic [WIDTH-1:0]  mem [DEPTH];

   // -------------------------------------------------------------------------
   // Sequencer state register
   // -------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state   <= CLEAR;
         clr_ptr <= '0;
      end else begin
         state   <= next_state;
         clr_ptr <= next_ptr;
      end
   end

   // -------------------------------------------------------------------------
   // Sequencer next-state / outputs
   // -------------------------------------------------------------------------
   always_comb begin
      next_state = state;
      next_ptr   = clr_ptr;
      clr_we     = 1'b0;
      Busy       = 1'b0;
      case (state)
         CLEAR: begin
            Busy   = 1'b1;
            clr_we = 1'b1;
            // The pointer is held on the last entry rather than wrapping, so
            // it is only meaningful while in CLEAR.
            if (clr_ptr == LAST_ADDR) begin
               next_state = RUN;
            end else begin
               next_ptr = clr_ptr + ADDR_W'(1);
            end
         end
         RUN: begin
            Busy = 1'b0;
         end
         default: begin
            next_state = CLEAR;
         end
      endcase
   end

   // -------------------------------------------------------------------------
   // Write qualification
   // -------------------------------------------------------------------------
   // A write to entry 0 is dropped when that entry is hardwired.
   // The same qualified enable drives both the array write and the bypass
   // compare, so a dropped write is never forwarded.
   always_comb begin
      wr_drop = ZERO_REG && (WriteReg == '0);
      wr_ok   = RegWrite && (state == RUN) && !wr_drop;
   end

   // -------------------------------------------------------------------------
   // Storage array (not reset directly; the clear sequencer zeroes it)
   // -------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst_n) begin
         if (clr_we) begin
            mem[clr_ptr] <= '0;
         end else if (wr_ok) begin
            mem[WriteReg] <= WriteData;
         end
      end
   end

   // -------------------------------------------------------------------------
   // Read ports
   // -------------------------------------------------------------------------
   // Priority, highest first: zero while clearing or for a hardwired r0,
   // then forwarded write data, then the stored value.
   always_comb begin
      Data1 = mem[Read1];
      if (BYPASS && wr_ok && (WriteReg == Read1)) begin
         Data1 = WriteData;
      end
      if (Busy || (ZERO_REG && (Read1 == '0))) begin
         Data1 = '0;
      end
   end

   always_comb begin
      Data2 = mem[Read2];
      if (BYPASS && wr_ok && (WriteReg == Read2)) begin
         Data2 = WriteData;
      end
      if (Busy || (ZERO_REG && (Read2 == '0))) begin
         Data2 = '0;
      end
   end

endmodule
